// File: rtl/lvds_rx_frame_align.sv
// LVDS receiver frame aligner.
// Watches the frame-clock lane (lane 8) of a 9-lane x 6-bit deserializer and
// issues bit-slip pulses until the lane shows FRAME_PATTERN for LOCK_COUNT
// consecutive words. Once locked, it tolerates up to LOSS_COUNT-1 consecutive
// bad words before dropping back to re-checking. Lanes 0-7 are passed through
// with one register stage.
module lvds_rx_frame_align #(
   parameter logic [5:0]  FRAME_PATTERN      = 6'b111000,
   parameter int unsigned ALIGN_PULSE_CYCLES = 2,
   parameter int unsigned SETTLE_CYCLES      = 4,
   parameter int unsigned LOCK_COUNT         = 16,
   parameter int unsigned LOSS_COUNT         = 4,
   parameter int unsigned MAX_SLIPS          = 12
) (
   input  logic        rx_clk,
   input  logic        reset,
   input  logic        rx_locked,
   input  logic [53:0] rx_data,
   output logic        rx_data_align,
   output logic        aligned,
   output logic [47:0] data_out,
   output logic        data_valid,
   output logic [3:0]  slip_count,
   output logic        align_err
);

   // Counter widths follow their terminal counts so each can hold its limit.
   localparam int unsigned MATCH_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned LOSS_W   = $clog2(LOSS_COUNT + 1);
   localparam int unsigned PULSE_W  = $clog2(ALIGN_PULSE_CYCLES + 1);
   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MATCH_W-1:0]  MATCH_MAX   = MATCH_W'(LOCK_COUNT);
   localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_COUNT - 1);
   localparam logic [LOSS_W-1:0]   LOSS_MAX    = LOSS_W'(LOSS_COUNT);
   localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(ALIGN_PULSE_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StSlip,
      StSettle,
      StLocked
   } state_t;

   state_t              state_q, state_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;
   logic [PULSE_W-1:0]  pulse_q, pulse_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [3:0]          slip_q, slip_d;
   logic                err_q, err_d;
   logic                aligned_q, aligned_d;
   logic                align_q;
   logic                valid_q;
   logic [47:0]         data_q;
   logic                frame_match;
   logic                slip_wrap;

   assign frame_match = (rx_data[53:48] == FRAME_PATTERN);

   // The slip that brings the count to MAX_SLIPS wraps it to zero and flags the error.
   assign slip_wrap = ((32'(slip_q) + 32'd1) == 32'(MAX_SLIPS));

   // State and counter registers.
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         match_q   <= '0;
         loss_q    <= '0;
         pulse_q   <= '0;
         settle_q  <= '0;
         slip_q    <= '0;
         err_q     <= 1'b0;
         aligned_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         match_q   <= match_d;
         loss_q    <= loss_d;
         pulse_q   <= pulse_d;
         settle_q  <= settle_d;
         slip_q    <= slip_d;
         err_q     <= err_d;
         aligned_q <= aligned_d;
      end
   end

   // Next-state and counter update; loss of PLL lock overrides everything else.
   always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      loss_d    = loss_q;
      pulse_d   = pulse_q;
      settle_d  = settle_q;
      slip_d    = slip_q;
      err_d     = err_q;
      aligned_d = aligned_q;

      if (!rx_locked) begin
         state_d   = StIdle;
         match_d   = '0;
         loss_d    = '0;
         pulse_d   = '0;
         settle_d  = '0;
         slip_d    = '0;
         aligned_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               match_d  = '0;
               loss_d   = '0;
               slip_d   = '0;
               settle_d = '0;
               state_d  = StSettle;
            end

            // Deserializer output is ignored while it settles after a slip.
            StSettle: begin
               if (settle_q == SETTLE_LAST) begin
                  settle_d = '0;
                  state_d  = StCheck;
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end

            StCheck: begin
               if (frame_match) begin
                  match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
                  if (match_q == MATCH_LAST) begin
                     loss_d    = '0;
                     aligned_d = 1'b1;
                     state_d   = StLocked;
                  end
               end else begin
                  match_d = '0;
                  pulse_d = '0;
                  state_d = StSlip;
                  if (slip_wrap) begin
                     slip_d = '0;
                     err_d  = 1'b1;
                  end else if (slip_q != 4'hf) begin
                     slip_d = slip_q + 1'b1;
                  end
               end
            end

            StSlip: begin
               if (pulse_q == PULSE_LAST) begin
                  pulse_d  = '0;
                  settle_d = '0;
                  state_d  = StSettle;
               end else begin
                  pulse_d = pulse_q + 1'b1;
               end
            end

            StLocked: begin
               if (frame_match) begin
                  loss_d = '0;
               end else if (loss_q == LOSS_LAST) begin
                  loss_d    = '0;
                  match_d   = '0;
                  aligned_d = 1'b0;
                  state_d   = StCheck;
               end else begin
                  loss_d = (loss_q == LOSS_MAX) ? loss_q : loss_q + 1'b1;
               end
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Registered outputs: slip request follows the next state so it is high
   // exactly for the cycles spent in SLIP; data path is a plain pipeline stage.
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         align_q <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         align_q <= (state_d == StSlip);
         valid_q <= (state_q == StLocked) && frame_match;
         data_q  <= rx_data[47:0];
      end
   end

   assign rx_data_align = align_q;
   assign aligned       = aligned_q;
   assign data_out      = data_q;
   assign data_valid    = valid_q;
   assign slip_count    = slip_q;
   assign align_err     = err_q;

endmodule

// File: tb/tb_lvds_rx_frame_align.sv
// Directed bench for lvds_rx_frame_align: lock from aligned data, slip
// recovery against a rotating deserializer model, slip exhaustion, loss of
// lock in LOCKED, PLL-lock drop mid-slip and asynchronous reset.
module tb_lvds_rx_frame_align;

   localparam logic [5:0] GOOD = 6'b111000;

   logic        rx_clk;
   logic        reset;
   logic        rx_locked;
   logic [53:0] rx_data;
   logic        rx_data_align;
   logic        aligned;
   logic [47:0] data_out;
   logic        data_valid;
   logic [3:0]  slip_count;
   logic        align_err;

   logic [5:0]  frame_drv;
   logic [5:0]  frame_lane;
   logic [47:0] lanes;
   logic        use_model;
   int          rot0;
   int          pulse_base;
   int          width_base;

   int vectors;
   int miscompares;

   // Monitor state (written only by the monitor process).
   int   pulses;
   int   bad_width;
   int   run;
   logic al_prev;

   lvds_rx_frame_align dut (
      .rx_clk        (rx_clk),
      .reset         (reset),
      .rx_locked     (rx_locked),
      .rx_data       (rx_data),
      .rx_data_align (rx_data_align),
      .aligned       (aligned),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .slip_count    (slip_count),
      .align_err     (align_err)
   );

   initial rx_clk = 1'b0;
   always #5 rx_clk = ~rx_clk;

   function automatic logic [5:0] rotl6(input logic [5:0] v, input int n);
      logic [11:0] t;
      t = {v, v} << n;
      return t[11:6];
   endfunction

   // Deserializer model: every slip pulse rotates the frame lane by one more bit.
   assign frame_lane = use_model ? rotl6(GOOD, (rot0 + pulses - pulse_base) % 6) : frame_drv;
   assign rx_data    = {frame_lane, lanes};

   // Counts slip pulses and records any pulse whose width is not two cycles.
   initial begin
      pulses    = 0;
      bad_width = 0;
      run       = 0;
      al_prev   = 1'b0;
   end
   always @(posedge rx_clk) begin
      if (rx_data_align) begin
         if (!al_prev) pulses <= pulses + 1;
         run <= al_prev ? run + 1 : 1;
      end else if (al_prev) begin
         if (run != 2) bad_width <= bad_width + 1;
      end
      al_prev <= rx_data_align;
   end

   task automatic tick();
      @(posedge rx_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_align"}, 64'(rx_data_align), 64'd0);
      chk({tag, "_aligned"}, 64'(aligned), 64'd0);
      chk({tag, "_valid"}, 64'(data_valid), 64'd0);
      chk({tag, "_slips"}, 64'(slip_count), 64'd0);
      chk({tag, "_err"}, 64'(align_err), 64'd0);
      chk({tag, "_data"}, 64'(data_out), 64'd0);
   endtask

   initial begin
      logic got;
      int   pb;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      rx_locked   = 1'b0;
      use_model   = 1'b0;
      frame_drv   = GOOD;
      lanes       = 48'h0123_4567_89ab;
      rot0        = 0;
      pulse_base  = 0;
      width_base  = 0;

      // Reset state.
      #12;
      chk_all_zero("rst");

      // Aligned frame lane: lock after 1 idle + 4 settle + 16 checks, no slips.
      rx_locked = 1'b1;
      tick();
      reset = 1'b0;
      pb    = pulses;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 1) chk("t1_data_latency", 64'(data_out), 64'h0123_4567_89ab);
         if (i == 20) chk("t1_not_yet_aligned", 64'(aligned), 64'd0);
      end
      tick();
      chk("t1_aligned", 64'(aligned), 64'd1);
      chk("t1_valid_lags", 64'(data_valid), 64'd0);
      lanes = 48'hfedc_ba98_7654;
      tick();
      chk("t1_valid", 64'(data_valid), 64'd1);
      chk("t1_data", 64'(data_out), 64'hfedc_ba98_7654);
      chk("t1_no_pulses", 64'(pulses - pb), 64'd0);
      chk("t1_slips", 64'(slip_count), 64'd0);

      // Locked: 3 bad words then a good one keep lock; 4 bad words drop it.
      frame_drv = 6'b000000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_hold_aligned", 64'(aligned), 64'd1);
         chk("t4_bad_invalid", 64'(data_valid), 64'd0);
      end
      frame_drv = GOOD;
      tick();
      chk("t4_recover_aligned", 64'(aligned), 64'd1);
      chk("t4_recover_valid", 64'(data_valid), 64'd1);
      frame_drv = 6'b000000;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t4_loss_valid", 64'(data_valid), 64'd0);
         chk("t4_loss_aligned", 64'(aligned), (i < 4) ? 64'd1 : 64'd0);
      end
      // Back in CHECK (not SETTLE): relock takes exactly 16 good words.
      frame_drv = GOOD;
      pb        = pulses;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 15) chk("t4_check_15", 64'(aligned), 64'd0);
         if (i == 16) chk("t4_check_16", 64'(aligned), 64'd1);
      end
      chk("t4_no_slip", 64'(pulses - pb), 64'd0);

      // Rotated by 3: three two-cycle pulses bring the lane into alignment.
      reset     = 1'b1;
      use_model = 1'b1;
      rot0      = 3;
      tick();
      pulse_base = pulses;
      width_base = bad_width;
      reset      = 1'b0;
      got        = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         tick();
         if (aligned) got = 1'b1;
      end
      chk("t2_lock_in_time", 64'(got), 64'd1);
      chk("t2_pulses", 64'(pulses - pulse_base), 64'd3);
      chk("t2_slip_count", 64'(slip_count), 64'd3);
      chk("t2_pulse_width", 64'(bad_width - width_base), 64'd0);
      chk("t2_err", 64'(align_err), 64'd0);

      // PLL lock drop in the first SLIP cycle.
      reset     = 1'b1;
      use_model = 1'b0;
      frame_drv = 6'b000000;
      tick();
      reset = 1'b0;
      got   = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         tick();
         if (rx_data_align) got = 1'b1;
      end
      chk("t5_slip_seen", 64'(got), 64'd1);
      chk("t5_slip_count_1", 64'(slip_count), 64'd1);
      rx_locked = 1'b0;
      tick();
      chk("t5_align_drop", 64'(rx_data_align), 64'd0);
      chk("t5_slips_clear", 64'(slip_count), 64'd0);
      chk("t5_aligned", 64'(aligned), 64'd0);
      tick();
      chk("t5_idle_quiet", 64'(rx_data_align), 64'd0);
      rx_locked = 1'b1;
      frame_drv = GOOD;
      pb        = pulses;
      for (int i = 1; i <= 21; i++) begin
         tick();
         if (i == 20) chk("t5_relock_20", 64'(aligned), 64'd0);
         if (i == 21) chk("t5_relock_21", 64'(aligned), 64'd1);
      end
      chk("t5_relock_no_slip", 64'(pulses - pb), 64'd0);

      // Frame lane stuck low: 12th slip flags align_err and wraps the count.
      reset     = 1'b1;
      frame_drv = 6'b000000;
      tick();
      pb         = pulses;
      width_base = bad_width;
      reset      = 1'b0;
      got        = 1'b0;
      for (int i = 0; i < 150 && !got; i++) begin
         tick();
         if (align_err) got = 1'b1;
      end
      chk("t3_err_in_time", 64'(got), 64'd1);
      chk("t3_wrap", 64'(slip_count), 64'd0);
      chk("t3_pulse_on", 64'(rx_data_align), 64'd1);
      chk("t3_not_aligned", 64'(aligned), 64'd0);
      tick();
      chk("t3_pulses_12", 64'(pulses - pb), 64'd12);
      repeat (14) tick();
      chk("t3_pulses_14", 64'(pulses - pb), 64'd14);
      chk("t3_slips_after_wrap", 64'(slip_count), 64'd2);
      chk("t3_err_sticky", 64'(align_err), 64'd1);
      chk("t3_still_unaligned", 64'(aligned), 64'd0);
      chk("t3_pulse_width", 64'(bad_width - width_base), 64'd0);

      // Fix the lane, lock, then reset asynchronously mid-cycle.
      frame_drv = GOOD;
      got       = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         tick();
         if (aligned) got = 1'b1;
      end
      chk("t6_lock_in_time", 64'(got), 64'd1);
      chk("t6_err_held", 64'(align_err), 64'd1);
      #3;
      reset = 1'b1;
      #1;
      chk_all_zero("t6_async");
      tick();
      reset = 1'b0;
      tick();
      chk("t6_post_release", 64'(aligned), 64'd0);
      chk("t6_post_err", 64'(align_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lvds_rx_frame_align.md
LVDS_RX_FRAME_ALIGN -- requirements
Module: lvds_rx_frame_align

Interface
REQ-001 The block SHALL have parameter FRAME_PATTERN, default 6'b111000, giving the expected 6-bit word on the frame-clock lane.
REQ-002 The block SHALL have parameter ALIGN_PULSE_CYCLES, default 2, giving the rx_data_align high time per slip.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the wait after each slip before re-checking.
REQ-004 The block SHALL have parameter LOCK_COUNT, default 16, giving the consecutive matching words required to declare alignment.
REQ-005 The block SHALL have parameter LOSS_COUNT, default 4, giving the consecutive mismatching words that drop alignment.
REQ-006 The block SHALL have parameter MAX_SLIPS, default 12, giving the slips tried before align_err is flagged.
REQ-007 Port: rx_clk  input  1  deserializer rx_outclock; the only clock.
REQ-008 Port: reset  input  1  asynchronous, active-high reset.
REQ-009 Port: rx_locked  input  1  deserializer PLL lock.
REQ-010 Port: rx_data  input  54  deserializer output, 9 lanes x 6 bits; lane n is bits [6n+5:6n]; lane 8 ([53:48]) is the frame-clock lane.
REQ-011 Port: rx_data_align  output  1  bit-slip request to the deserializer.
REQ-012 Port: aligned  output  1  frame alignment achieved.
REQ-013 Port: data_out  output  48  lanes 0-7 ([47:0] of rx_data), registered.
REQ-014 Port: data_valid  output  1  data_out qualifier.
REQ-015 Port: slip_count  output  4  slips issued since the last restart, saturating at 15.
REQ-016 Port: align_err  output  1  sticky flag: MAX_SLIPS reached without lock.

Function
REQ-017 The block SHALL implement FSM states IDLE, CHECK, SLIP, SETTLE and LOCKED.
REQ-018 IDLE SHALL clear the match counter, loss counter and slip_count, and SHALL go to SETTLE when rx_locked=1.
REQ-019 In CHECK, a frame-lane match SHALL increment the match counter and go to LOCKED when the count reaches LOCK_COUNT.
REQ-020 In CHECK, a mismatch SHALL clear the match counter, increment slip_count and enter SLIP.
REQ-021 SLIP SHALL hold rx_data_align=1 for exactly ALIGN_PULSE_CYCLES cycles, then enter SETTLE with rx_data_align=0.
REQ-022 SETTLE SHALL wait exactly SETTLE_CYCLES cycles, ignoring rx_data, then enter CHECK.
REQ-023 rx_data_align SHALL be 1 only in SLIP.
REQ-024 When slip_count reaches MAX_SLIPS, the block SHALL set align_err=1, reset slip_count to 0 and continue slipping.
REQ-025 align_err SHALL clear only on reset.
REQ-026 In LOCKED, aligned SHALL be 1.
REQ-027 In LOCKED, each mismatch SHALL increment the loss counter and each match SHALL clear it.
REQ-028 When the loss counter reaches LOSS_COUNT, the block SHALL clear aligned and the match counter and enter CHECK.
REQ-029 rx_locked=0 in any state SHALL force IDLE on the next edge and clear aligned, with priority over all other transitions.
REQ-030 In a SLIP-state cycle with rx_locked=0, rx_data_align SHALL drop on the next edge.
REQ-031 data_out SHALL register rx_data[47:0] every cycle, giving one cycle of latency.
REQ-032 data_valid SHALL be 1 one cycle after a cycle in LOCKED whose frame lane equals FRAME_PATTERN, else 0.
REQ-033 Counters SHALL be sized from their parameters, and match and loss counters SHALL saturate, never wrap.

Reset
REQ-034 On reset=1 the block SHALL asynchronously enter IDLE.
REQ-035 On reset=1 the block SHALL asynchronously drive rx_data_align=0, aligned=0, data_valid=0, align_err=0, slip_count=0 and data_out=0.
REQ-036 Reset release SHALL take effect on the first rx_clk edge after reset deasserts.
REQ-037 Reset asserted mid-SLIP SHALL drop rx_data_align immediately, without waiting for an edge.

Verification
REQ-038 The bench SHALL cover: frame lane constant 111000 and rx_locked=1 after reset -> no rx_data_align pulse; aligned=1 after 4 (SETTLE) + 16 cycles; data_valid follows one cycle later.
REQ-039 The bench SHALL cover: deserializer model rotated by 3 bits that rotates by 1 per rx_data_align pulse -> exactly 3 pulses, each 2 cycles wide; slip_count=3; aligned=1.
REQ-040 The bench SHALL cover: frame lane stuck at 000000 -> align_err=1 after the 12th slip; slip_count wraps to 0; pulses continue; aligned stays 0.
REQ-041 The bench SHALL cover, in LOCKED: 3 mismatches then a match -> aligned stays 1; 4 consecutive mismatches -> aligned=0, CHECK entered, data_valid=0 on the mismatching words.
REQ-042 The bench SHALL cover: rx_locked dropped mid-SLIP -> rx_data_align=0 next edge, IDLE entered, slip_count=0; re-lock restarts from SETTLE.
REQ-043 The bench SHALL cover: reset pulsed asynchronously between edges while aligned=1 -> all outputs 0 immediately; align_err=0.
